// File: rtl/spad_pipe.sv
// -----------------------------------------------------------------------------
// spad_pipe -- byte-maskable scratchpad RAM with a registered, back-pressured
// read port.
//
// After reset a CLEAR sweep writes zero to every location, one per cycle, while
// busy is high and both request ports are closed. The block then enters RUN,
// where it takes one masked write and one read request per cycle. Read data
// arrives one cycle after acceptance and is held while the consumer stalls.
//
// Optional build macro:
//   SPAD_PIPE_FWD_EN  - a read and a write accepted in the same cycle at the
//                       same address return the freshly merged word instead of
//                       the old one.
// -----------------------------------------------------------------------------
module spad_pipe #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    // write request channel
    input  logic                    wvalid,
    output logic                    wready,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    // read request channel
    input  logic                    rreq_valid,
    output logic                    rreq_ready,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    // read data channel
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   rdata,
    // status
    output logic                    busy
);

    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // Byte lanes must tile the word exactly.
    if ((DATA_WIDTH < 8) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_data_width
        $error("spad_pipe: DATA_WIDTH (%0d) must be a multiple of 8 and >= 8",
               DATA_WIDTH);
    end

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic                    run;        // registered copy of (state == RUN)

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    wr_fire;
    logic                    rd_fire;
    logic [DATA_WIDTH-1:0]   rd_word;

    // -------------------------------------------------------------------------
    // Handshakes. Both request ports stay closed until the sweep is done; the
    // read request port additionally closes while undelivered data is stalled.
    // -------------------------------------------------------------------------
    assign wready     = run;
    assign rreq_ready = run && (!rvalid || rready);
    assign wr_fire    = wvalid && wready;
    assign rd_fire    = rreq_valid && rreq_ready;

    // Sweep control: CLEAR walks clr_cnt over every address, then hands over to
    // RUN; busy and run are registered alongside the state.
    // NOTE: every register in a clocked block uses <= so all of them update
    // from the same pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
            run     <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
                    if (&clr_cnt) begin
                        state <= RUN;
                        busy  <= 1'b0;
                        run   <= 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= CLEAR;
                    busy  <= 1'b1;
                    run   <= 1'b0;
                end
            endcase
        end
    end

    // Storage: zero fill during CLEAR, byte-masked writes during RUN.
    // NOTE: the array has no reset branch on purpose; a reset term would turn
    // it into thousands of flops. The CLEAR sweep provides the defined state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= '0;
            end else if (wr_fire) begin
                for (int b = 0; b < STRB_WIDTH; b++) begin
                    if (wstrb[b]) begin
                        mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
        end
    end

`ifdef SPAD_PIPE_FWD_EN
    // Replace the byte lanes selected by strb in old_word with new_word.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [STRB_WIDTH-1:0] strb
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int b = 0; b < STRB_WIDTH; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

    // Word to capture on an accepted read, with same-address write bypass.
    // NOTE: rd_word gets a value on every path through this block before any
    // condition is tested, so no latch can be inferred.
    always_comb begin
        rd_word = mem[raddr];
        if (wr_fire && (waddr == raddr)) begin
            rd_word = merge_bytes(mem[raddr], wdata, wstrb);
        end
    end
`else
    // Word to capture on an accepted read: always the pre-write contents.
    always_comb begin
        rd_word = mem[raddr];
    end
`endif

    // Read data register: load on acceptance, hold under back-pressure, drop
    // valid once consumed while keeping the last word on rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else if (rd_fire) begin
            rvalid <= 1'b1;
            rdata  <= rd_word;
        end else if (rready) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spad_pipe.sv
// -----------------------------------------------------------------------------
// tb_spad_pipe -- scoreboard bench for spad_pipe (ADDR_WIDTH=4, DATA_WIDTH=32).
// Honours SPAD_PIPE_FWD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_spad_pipe;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

`ifdef SPAD_PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          rreq_valid = 1'b0;
    logic          rreq_ready;
    logic [AW-1:0] raddr = '0;
    logic          rvalid;
    logic          rready = 1'b0;
    logic [DW-1:0] rdata;
    logic          busy;

    spad_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .wvalid     (wvalid),
        .wready     (wready),
        .waddr      (waddr),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .rreq_valid (rreq_valid),
        .rreq_ready (rreq_ready),
        .raddr      (raddr),
        .rvalid     (rvalid),
        .rready     (rready),
        .rdata      (rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference state
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    bit            m_rvalid   = 1'b0;
    int            clear_left = DEPTH;
    int            busy_cycles = 0;
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Masked byte update expressed as plain mask arithmetic.
    function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_w,
                                                 input logic [DW-1:0] new_w,
                                                 input logic [3:0] strb);
        logic [DW-1:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) mask = mask | (32'hFF << (8 * i));
        end
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    // One clock cycle: drive, evaluate the reference at the negedge, return
    // 1 time unit after the next rising edge.
    task automatic cycle(input bit r, input bit wv, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic [3:0] ws,
                         input bit rv, input logic [AW-1:0] ra, input bit rr);
        bit            run_now, exp_rrdy, rd_acc, wr_acc;
        logic [DW-1:0] exp_word;
        rst = r; wvalid = wv; waddr = wa; wdata = wd; wstrb = ws;
        rreq_valid = rv; raddr = ra; rready = rr;
        @(negedge clk);
        if (rst) begin
            clear_left = DEPTH;
            m_rvalid   = 1'b0;
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end else begin
            run_now  = (clear_left == 0);
            exp_rrdy = run_now && (!m_rvalid || rready);
            check("busy", 64'(busy), 64'(!run_now));
            check("wready", 64'(wready), 64'(run_now));
            check("rreq_ready", 64'(rreq_ready), 64'(exp_rrdy));
            check("rvalid", 64'(rvalid), 64'(m_rvalid));
            if (busy) busy_cycles++;
            rd_acc = exp_rrdy && rreq_valid;
            wr_acc = run_now && wvalid;
            if (rd_acc) begin
                exp_word = ref_mem[raddr];
                if (FWD && wr_acc && (waddr == raddr))
                    exp_word = apply_strb(exp_word, wdata, wstrb);
                exp_q.push_back(exp_word);
            end
            if (wr_acc) ref_mem[waddr] = apply_strb(ref_mem[waddr], wdata, wstrb);
            if (rd_acc) m_rvalid = 1'b1;
            else if (rready) m_rvalid = 1'b0;
            if (clear_left > 0) clear_left--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, '0, 0, '0, rr);
    endtask

    // Monitor: pop and compare on every delivered word; verify hold on stall.
    bit            hold_prev = 1'b0;
    logic [DW-1:0] hold_data = '0;
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_rvalid", 64'(rvalid), 64'(1));
                check("hold_rdata", 64'(rdata), 64'(hold_data));
            end
            if (rvalid && rready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rdata", 64'(1), 64'(0));
                end else begin
                    check("rdata", 64'(rdata), 64'(exp_q.pop_front()));
                end
            end
            hold_prev = rvalid && !rready;
            hold_data = rdata;
        end
    end

    initial begin
        // Power-up reset and sweep length
        for (int i = 0; i < 3; i++) cycle(1, 0, '0, '0, '0, 0, '0, 0);
        busy_cycles = 0;
        idle(20, 1);
        check("busy_len_initial", 64'(busy_cycles), 64'(16));

        // Freshly cleared location reads zero
        cycle(0, 0, '0, '0, '0, 1, 4'd5, 1);
        check("rdata_addr5_zero", 64'(rdata), 64'(0));
        idle(2, 1);

        // Byte-masked overwrite
        cycle(0, 1, 4'd3, 32'hDEADBEEF, 4'hF, 0, '0, 1);
        cycle(0, 1, 4'd3, 32'h12345678, 4'h3, 0, '0, 1);
        cycle(0, 0, '0, '0, '0, 1, 4'd3, 1);
        check("rdata_addr3_merge", 64'(rdata), 64'(32'hDEAD5678));
        idle(2, 1);

        // Stall: data held, no new request taken, then same-cycle re-accept
        cycle(0, 0, '0, '0, '0, 1, 4'd3, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, '0, '0, '0, 1, 4'd3, 0);
        cycle(0, 0, '0, '0, '0, 1, 4'd4, 1);
        idle(2, 1);

        // Same-cycle write/read to one address
        cycle(0, 1, 4'd7, 32'h11111111, 4'hF, 0, '0, 1);
        cycle(0, 1, 4'd7, 32'hAAAAAAAA, 4'hF, 1, 4'd7, 1);
        check("rdata_addr7_same_cycle", 64'(rdata), FWD ? 64'(32'hAAAAAAAA) : 64'(32'h11111111));
        idle(2, 1);

        // Reset discards pending read data
        cycle(0, 0, '0, '0, '0, 1, 4'd3, 0);
        cycle(1, 0, '0, '0, '0, 0, '0, 0);
        check("rvalid_after_rst", 64'(rvalid), 64'(0));
        check("rdata_after_rst", 64'(rdata), 64'(0));
        check("busy_after_rst", 64'(busy), 64'(1));

        // Reset in the sweep cycle that clears address 7
        idle(7, 1);
        cycle(1, 0, '0, '0, '0, 0, '0, 1);
        busy_cycles = 0;
        idle(20, 1);
        check("busy_len_restart", 64'(busy_cycles), 64'(16));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] wa, ra;
            wa = AW'($urandom_range(DEPTH - 1));
            ra = ($urandom_range(3) == 0) ? wa : AW'($urandom_range(DEPTH - 1));
            cycle(0, $urandom_range(1) == 1, wa, $urandom, 4'($urandom_range(15)),
                  $urandom_range(1) == 1, ra, $urandom_range(3) != 0);
        end
        idle(5, 1);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spad_pipe.md
SPAD_PIPE -- requirements
Module: spad_pipe

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, address bits; depth DEPTH = 2^ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word bits; legal values are multiples of 8 that are >= 8; any other value SHALL cause an elaboration error.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wvalid  input  1  write request.
REQ-006 SHALL have port wready  output  1  write accept.
REQ-007 SHALL have port waddr  input  ADDR_WIDTH  write address.
REQ-008 SHALL have port wdata  input  DATA_WIDTH  write data.
REQ-009 SHALL have port wstrb  input  DATA_WIDTH/8  byte enables; bit i covers wdata[8i+7:8i].
REQ-010 SHALL have port rreq_valid  input  1  read request.
REQ-011 SHALL have port rreq_ready  output  1  read request accept.
REQ-012 SHALL have port raddr  input  ADDR_WIDTH  read address.
REQ-013 SHALL have port rvalid  output  1  read data valid.
REQ-014 SHALL have port rready  input  1  read data consumed.
REQ-015 SHALL have port rdata  output  DATA_WIDTH  registered read data.
REQ-016 SHALL have port busy  output  1  clear sweep in progress.

Function
REQ-017 SHALL implement a two-state FSM: CLEAR, RUN.
REQ-018 CLEAR SHALL write zero to address clr_cnt each cycle, clr_cnt incrementing from 0 to DEPTH-1, then enter RUN on the following edge; the sweep takes exactly DEPTH cycles.
REQ-019 In CLEAR, busy SHALL be 1 and wready, rreq_ready SHALL be 0; in RUN, busy SHALL be 0.
REQ-020 In RUN, wready SHALL be 1; a write is accepted when wvalid && wready.
REQ-021 An accepted write SHALL update only the bytes whose wstrb bit is 1; wstrb = 0 SHALL leave the word unchanged.
REQ-022 rreq_ready SHALL equal (state==RUN) && (!rvalid || rready).
REQ-023 An accepted read (rreq_valid && rreq_ready) SHALL load rdata with mem[raddr] and set rvalid on the next edge; latency is 1 cycle.
REQ-024 While rvalid && !rready, rdata and rvalid SHALL hold unchanged.
REQ-025 When rvalid && rready and no read is accepted in the same cycle, rvalid SHALL clear on the next edge and rdata SHALL hold its value.
REQ-026 Back-to-back reads with rready=1 SHALL sustain one read per cycle.
REQ-027 A write and a read to different addresses in the same cycle SHALL both complete; the read SHALL return the pre-write contents of its own address.
REQ-028 Address wrap SHALL NOT occur; every ADDR_WIDTH value is a valid location.

Reset
REQ-029 When rst=1 at an edge, the FSM SHALL enter CLEAR, clr_cnt SHALL be 0, rvalid SHALL be 0, rdata SHALL be 0 and busy SHALL be 1 from the next cycle.
REQ-030 Reset mid-sweep SHALL restart the sweep at address 0; reset with rvalid=1 SHALL discard the pending data.
REQ-031 Memory contents SHALL be undefined only until the sweep completes; the sweep SHALL overwrite every location.

Configuration
REQ-032 Macro SPAD_PIPE_FWD_EN SHALL select same-address read/write forwarding.
REQ-033 With SPAD_PIPE_FWD_EN defined, a same-cycle accepted read and write to the same address SHALL return the old word with the bytes enabled by wstrb replaced by wdata.
REQ-034 Without SPAD_PIPE_FWD_EN, that read SHALL return the old word; the write SHALL still complete.

Verification (ADDR_WIDTH=4, DATA_WIDTH=32)
REQ-035 Release rst -> busy=1 for exactly 16 cycles, then 0; read address 5 -> rdata=0x00000000 one cycle after acceptance.
REQ-036 Write 0xDEADBEEF to address 3 with wstrb 0xF, then 0x12345678 with wstrb 0x3; read address 3 -> rdata=0xDEAD5678.
REQ-037 Read address 3 with rready=0 for 3 cycles -> rvalid=1 and rdata stable, rreq_ready=0 throughout; rready=1 -> new read accepted in the same cycle.
REQ-038 Address 7 holds 0x11111111; write 0xAAAAAAAA to address 7 with wstrb 0xF and read address 7 in the same cycle -> rdata=0xAAAAAAAA with SPAD_PIPE_FWD_EN, rdata=0x11111111 without it.
REQ-039 Assert rst when clr_cnt=7 -> busy stays 1 for exactly 16 further cycles; assert rst while rvalid=1 -> rvalid=0 next cycle.
